// File: rtl/gpmc_async_host_engine.sv
// GPMC asynchronous host engine: executes single/multi-word reads and writes on a
// multiplexed AD bus with per-signal cycle timing, wait stalling and timeout.
module gpmc_async_host_engine #(
  parameter int DW           = 16,
  parameter int LEN_W        = 8,
  parameter int CS_ON        = 0,
  parameter int CS_RD_OFF    = 5,
  parameter int CS_WR_OFF    = 5,
  parameter int ADV_ON       = 0,
  parameter int ADV_RD_OFF   = 2,
  parameter int ADV_WR_OFF   = 2,
  parameter int OE_ON        = 3,
  parameter int OE_OFF       = 6,
  parameter int WE_ON        = 3,
  parameter int WE_OFF       = 5,
  parameter int RD_CYCLE     = 6,
  parameter int WR_CYCLE     = 6,
  parameter int RD_ACCESS    = 5,
  parameter int WR_DATA_ON   = 3,
  parameter int C2C_DELAY    = 1,
  parameter int WAIT_EN      = 0,
  parameter int WAIT_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [DW-1:0]    cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [DW-1:0]    wr_data,
  output logic             wr_ready,
  output logic [DW-1:0]    rd_data,
  output logic             rd_valid,
  output logic             cmd_done,
  output logic             cmd_err,
  output logic             busy,
  output logic             gpmc_clk,
  output logic             gpmc_csn,
  output logic             gpmc_advn,
  output logic             gpmc_oen,
  output logic             gpmc_wen,
  output logic [1:0]       gpmc_ben,
  output logic [DW-1:0]    gpmc_ad_out,
  output logic             gpmc_ad_oe,
  input  logic [DW-1:0]    gpmc_ad_in,
  input  logic             gpmc_wait
);

  localparam int CMAX_A = (RD_CYCLE > WR_CYCLE) ? RD_CYCLE : WR_CYCLE;
  localparam int CMAX   = (CMAX_A > C2C_DELAY) ? CMAX_A : C2C_DELAY;
  localparam int CW     = $clog2(CMAX + 1);
  localparam int SW     = $clog2(WAIT_TIMEOUT + 2);

  typedef enum logic [1:0] {IDLE, ACCESS, DELAY} state_t;

  state_t           state_q, state_n;
  logic [CW-1:0]    c_q, c_n;
  logic [SW-1:0]    stall_q, stall_n;
  logic [DW-1:0]    addr_q, addr_n, wdata_q, wdata_n;
  logic [LEN_W-1:0] word_q, word_n, len_q;
  logic             write_q, start_q, err_q, err_n;
  logic             accept, word_start, word_end, done_n, sample, freeze, force_prog;
  logic             csn_n, advn_n, oen_n, wen_n, ad_oe_n;
  logic [1:0]       ben_n;
  logic [DW-1:0]    ad_out_n;
  int               cyc, stall_pt, cc;

  function automatic logic in_win(input int c, input int on, input int off);
    return (c >= on) && (c < off);
  endfunction

  assign gpmc_clk = 1'b0;

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_n    = state_q;
    c_n        = c_q;
    stall_n    = stall_q;
    addr_n     = addr_q;
    word_n     = word_q;
    err_n      = err_q;
    wdata_n    = wr_ready ? wr_data : wdata_q;
    accept     = cmd_valid && cmd_ready;
    word_start = 1'b0;
    word_end   = 1'b0;
    done_n     = 1'b0;
    sample     = 1'b0;
    freeze     = 1'b0;
    force_prog = 1'b0;
    cyc        = write_q ? WR_CYCLE : RD_CYCLE;
    stall_pt   = write_q ? (WE_OFF - 1) : (RD_ACCESS - 1);
    cc         = 0;

    unique case (state_q)
      IDLE: begin
        if (start_q) begin
          state_n    = ACCESS;
          c_n        = '0;
          word_start = 1'b1;
        end else if (accept) begin
          addr_n = cmd_addr;
          word_n = '0;
          err_n  = 1'b0;
        end
      end
      ACCESS: begin
        if (WAIT_EN != 0 && int'(c_q) == stall_pt && !gpmc_wait) begin
          if (int'(stall_q) <= WAIT_TIMEOUT) freeze = 1'b1;
          else                               force_prog = 1'b1;
        end
        if (freeze) begin
          stall_n = stall_q + SW'(1);
        end else begin
          stall_n = '0;
          if (force_prog) err_n = 1'b1;
          sample = !write_q && (int'(c_q) == RD_ACCESS - 1);
          if (int'(c_q) == cyc - 1) begin
            if (C2C_DELAY > 0) begin
              state_n = DELAY;
              c_n     = '0;
            end else begin
              word_end = 1'b1;
            end
          end else begin
            c_n = c_q + CW'(1);
          end
        end
      end
      DELAY: begin
        if (int'(c_q) >= C2C_DELAY - 1) word_end = 1'b1;
        else                            c_n = c_q + CW'(1);
      end
      default: state_n = IDLE;
    endcase

    if (word_end) begin
      if (word_q == len_q) begin
        state_n = IDLE;
        done_n  = 1'b1;
      end else begin
        state_n    = ACCESS;
        c_n        = '0;
        addr_n     = addr_q + DW'(1);
        word_n     = word_q + LEN_W'(1);
        word_start = 1'b1;
      end
    end

    // Bus outputs are computed for the cycle being entered, then registered.
    csn_n    = 1'b1;
    advn_n   = 1'b0;
    oen_n    = 1'b1;
    wen_n    = 1'b1;
    ben_n    = 2'b11;
    ad_oe_n  = 1'b1;
    ad_out_n = '0;
    if (state_n == ACCESS) begin
      cc    = int'(c_n);
      ben_n = 2'b00;
      if (write_q) begin
        csn_n    = !in_win(cc, CS_ON, CS_WR_OFF);
        advn_n   = !in_win(cc, ADV_ON, ADV_WR_OFF);
        wen_n    = !in_win(cc, WE_ON, WE_OFF);
        ad_out_n = (cc < WR_DATA_ON) ? addr_n : wdata_n;
      end else begin
        csn_n    = !in_win(cc, CS_ON, CS_RD_OFF);
        advn_n   = !in_win(cc, ADV_ON, ADV_RD_OFF);
        oen_n    = !in_win(cc, OE_ON, OE_OFF);
        ad_oe_n  = (cc < OE_ON);
        ad_out_n = addr_n;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      c_q         <= '0;
      stall_q     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      word_q      <= '0;
      len_q       <= '0;
      write_q     <= 1'b0;
      start_q     <= 1'b0;
      err_q       <= 1'b0;
      cmd_ready   <= 1'b1;
      busy        <= 1'b0;
      wr_ready    <= 1'b0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      cmd_done    <= 1'b0;
      cmd_err     <= 1'b0;
      gpmc_csn    <= 1'b1;
      gpmc_advn   <= 1'b0;
      gpmc_oen    <= 1'b1;
      gpmc_wen    <= 1'b1;
      gpmc_ben    <= 2'b11;
      gpmc_ad_oe  <= 1'b1;
      gpmc_ad_out <= '0;
    end else begin
      state_q     <= state_n;
      c_q         <= c_n;
      stall_q     <= stall_n;
      addr_q      <= addr_n;
      wdata_q     <= wdata_n;
      word_q      <= word_n;
      err_q       <= err_n;
      start_q     <= accept;
      if (accept) begin
        write_q   <= cmd_write;
        len_q     <= cmd_len;
        busy      <= 1'b1;
        cmd_ready <= 1'b0;
      end else if (cmd_done) begin
        busy      <= 1'b0;
        cmd_ready <= 1'b1;
      end
      wr_ready    <= word_start && write_q;
      rd_valid    <= sample;
      if (sample) rd_data <= gpmc_ad_in;
      cmd_done    <= done_n;
      cmd_err     <= done_n && err_n;
      gpmc_csn    <= csn_n;
      gpmc_advn   <= advn_n;
      gpmc_oen    <= oen_n;
      gpmc_wen    <= wen_n;
      gpmc_ben    <= ben_n;
      gpmc_ad_oe  <= ad_oe_n;
      gpmc_ad_out <= ad_out_n;
    end
  end

endmodule
